weight_settler: RTL and testbench



---
 rtl/sorter_pkg.sv | 18 +
 rtl/weight_window_cmp.sv | 37 +++
 rtl/weight_settler.sv | 124 ++++++++++++
 tb/tb_weight_settler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared constants for the package sorter: settler state encoding and the
// default weight-path parameters so every stage agrees on the weight width.
package sorter_pkg;

  localparam int unsigned DEF_WIDTH         = 12;
  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_TOL           = 2;
  localparam int unsigned DEF_ZERO_THRESH   = 3;
  localparam int unsigned COUNT_WIDTH       = 16;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REMOVING = 2'd3
  } settle_state_e;

endpackage

// File: rtl/weight_window_cmp.sv
// Combinational sample classifier: flags an empty-scale reading and whether
// the raw reading sits within TOL of the current reference weight.
module weight_window_cmp
  import sorter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned ZERO_THRESH = DEF_ZERO_THRESH
) (
  input  logic [WIDTH-1:0] raw_i,
  input  logic [WIDTH-1:0] ref_i,
  output logic             is_zero_o,
  output logic             in_window_o
);

  // The difference carries one extra bit so it can never wrap.
  localparam logic [WIDTH:0]   TOL_W  = (WIDTH+1)'(TOL);
  localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(ZERO_THRESH);

  logic [WIDTH:0] raw_ext_s;
  logic [WIDTH:0] ref_ext_s;
  logic [WIDTH:0] diff_s;

  // Absolute difference and the two sample classifications.
  always_comb begin
    raw_ext_s = {1'b0, raw_i};
    ref_ext_s = {1'b0, ref_i};
    if (raw_ext_s >= ref_ext_s) begin
      diff_s = raw_ext_s - ref_ext_s;
    end else begin
      diff_s = ref_ext_s - raw_ext_s;
    end
    is_zero_o   = (raw_i <= ZERO_W);
    in_window_o = (diff_s <= TOL_W);
  end

endmodule

// File: rtl/weight_settler.sv
// Debounces the raw scale reading into one held weight per item, presenting
// a clean zero between items and counting every item that is placed and
// then removed.
module weight_settler
  import sorter_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned TOL           = DEF_TOL,
  parameter int unsigned ZERO_THRESH   = DEF_ZERO_THRESH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       raw_weight,
  output logic [WIDTH-1:0]       weight,
  output logic                   valid,
  output logic [COUNT_WIDTH-1:0] item_count,
  output logic [1:0]             state
);

  localparam int unsigned    CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  settle_state_e          state_q;
  logic [WIDTH-1:0]       ref_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [WIDTH-1:0]       weight_q;
  logic                   valid_q;
  logic [COUNT_WIDTH-1:0] item_count_q;

  logic             is_zero_s;
  logic             in_window_s;
  logic [CNT_W-1:0] cnt_inc_s;

  weight_window_cmp #(
    .WIDTH       (WIDTH),
    .TOL         (TOL),
    .ZERO_THRESH (ZERO_THRESH)
  ) u_cmp (
    .raw_i       (raw_weight),
    .ref_i       (ref_q),
    .is_zero_o   (is_zero_s),
    .in_window_o (in_window_s)
  );

  assign cnt_inc_s = cnt_q + CNT_ONE;

  // Settling FSM: reference/stability tracking plus the registered outputs.
  // The held weight only moves 0->W on acceptance and W->0 on removal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      ref_q        <= '0;
      cnt_q        <= CNT_ZERO;
      weight_q     <= '0;
      valid_q      <= 1'b0;
      item_count_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (!is_zero_s) begin
            ref_q   <= raw_weight;
            cnt_q   <= CNT_ONE;
            state_q <= ST_SETTLING;
          end
        end
        ST_SETTLING: begin
          if (is_zero_s) begin
            cnt_q   <= CNT_ZERO;
            state_q <= ST_EMPTY;
          end else if (!in_window_s) begin
            // A new level restarts the window; the reference is never averaged.
            ref_q <= raw_weight;
            cnt_q <= CNT_ONE;
          end else begin
            cnt_q <= cnt_inc_s;
            if (cnt_inc_s == STABLE_CNT) begin
              state_q  <= ST_HOLD;
              weight_q <= ref_q;
              valid_q  <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Nonzero jitter of any size is ignored while an item is held.
          if (is_zero_s) begin
            cnt_q   <= CNT_ONE;
            state_q <= ST_REMOVING;
          end
        end
        ST_REMOVING: begin
          if (!is_zero_s) begin
            // A bounce back to load: the item is still there, nothing counted.
            cnt_q   <= CNT_ZERO;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_inc_s;
            if (cnt_inc_s == STABLE_CNT) begin
              cnt_q        <= CNT_ZERO;
              state_q      <= ST_EMPTY;
              weight_q     <= '0;
              valid_q      <= 1'b0;
              item_count_q <= item_count_q + COUNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_q  <= ST_EMPTY;
          cnt_q    <= CNT_ZERO;
          weight_q <= '0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign weight     = weight_q;
  assign valid      = valid_q;
  assign item_count = item_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_weight_settler.sv
// Self-checking bench for weight_settler: directed scenarios with literal
// expectations, then randomized item traffic against a behavioural model.
module tb_weight_settler;

  localparam int W  = 12;
  localparam int SC = 4;
  localparam int TL = 2;
  localparam int ZT = 3;

  logic          clk;
  logic          reset;
  logic [W-1:0]  raw_weight;
  logic [W-1:0]  weight;
  logic          valid;
  logic [15:0]   item_count;
  logic [1:0]    state;

  int n_checks;
  int n_errors;
  bit cmp_en;

  // Behavioural model: an item is either absent or present; while absent we
  // may be tracking a candidate level, while present we may be watching it leave.
  bit        m_tracking;
  bit        m_present;
  bit        m_leaving;
  int        m_anchor;
  int        m_run;
  int        m_weight;
  logic [15:0] m_count;
  logic [W-1:0] prev_weight;

  weight_settler #(
    .WIDTH         (W),
    .STABLE_CYCLES (SC),
    .TOL           (TL),
    .ZERO_THRESH   (ZT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_weight (raw_weight),
    .weight     (weight),
    .valid      (valid),
    .item_count (item_count),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int m_state();
    if (m_present) return m_leaving ? 3 : 2;
    return m_tracking ? 1 : 0;
  endfunction

  // Model update on each sampled reading; asynchronous clear on reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_tracking = 0; m_present = 0; m_leaving = 0;
      m_anchor = 0; m_run = 0; m_weight = 0; m_count = 16'h0000;
    end else begin
      int  v;
      bit  empty_scale;
      v = int'(raw_weight);
      empty_scale = (v <= ZT);
      if (!m_present) begin
        if (empty_scale) begin
          m_tracking = 0; m_run = 0;
        end else if (!m_tracking || ((v > m_anchor ? v - m_anchor : m_anchor - v) > TL)) begin
          m_tracking = 1; m_anchor = v; m_run = 1;
        end else begin
          m_run = m_run + 1;
          if (m_run == SC) begin
            m_present = 1; m_tracking = 0; m_weight = m_anchor;
          end
        end
      end else begin
        if (!empty_scale) begin
          m_leaving = 0; m_run = 0;
        end else if (!m_leaving) begin
          m_leaving = 1; m_run = 1;
        end else begin
          m_run = m_run + 1;
          if (m_run == SC) begin
            m_present = 0; m_leaving = 0; m_weight = 0; m_run = 0;
            m_count = m_count + 16'h0001;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("weight", weight, m_weight);
      chk("valid", valid, m_present);
      chk("item_count", item_count, m_count);
      chk("state", state, m_state());
      if (weight !== prev_weight && weight != '0 && prev_weight != '0) begin
        chk("weight_jump", weight, prev_weight);
      end
      prev_weight = weight;
    end
  end

  task automatic step(input int v);
    raw_weight = W'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic rand_item();
    int w;
    int v;
    int n;
    w = int'($urandom_range(10, 4090));
    n = int'($urandom_range(0, 3));
    for (int k = 0; k < n; k++) step(int'($urandom_range(4, 4095)));
    n = SC + int'($urandom_range(0, 6));
    for (int k = 0; k < n; k++) begin
      v = w + int'($urandom_range(0, 2 * TL + 2)) - TL - 1;
      if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, 3));
      step(v);
    end
    n = int'($urandom_range(0, 6));
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 4) == 0) step(int'($urandom_range(0, 3)));
      else step(int'($urandom_range(4, 4095)));
    end
    if ($urandom_range(0, 24) == 0) pulse_reset();
    n = int'($urandom_range(1, 10));
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 5) == 0) step(int'($urandom_range(4, 4095)));
      else step(int'($urandom_range(0, 3)));
    end
    steps(0, int'($urandom_range(0, 3)));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cmp_en = 1'b0;
    prev_weight = '0;
    raw_weight = W'(700);
    reset = 1'b0;
    #2;
    // Reset state, held while reset stays asserted with a loaded scale.
    chk("rst_weight", weight, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", item_count, 0);
    chk("rst_state", state, 0);
    cmp_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_hold_weight", weight, 0);
    chk("rst_hold_state", state, 0);
    raw_weight = '0;
    reset = 1'b1;
    step(0);

    // Clean step to 500: accepted on the 4th sampling edge.
    steps(500, 3);
    chk("t2_settling", state, 1);
    chk("t2_not_yet", valid, 0);
    step(500);
    chk("t2_weight", weight, 500);
    chk("t2_valid", valid, 1);
    chk("t2_state", state, 2);

    // Short lift is a bounce; a full lift counts one item.
    steps(0, 2);
    chk("t4_removing", state, 3);
    step(500);
    chk("t4_back_hold", state, 2);
    chk("t4_weight_kept", weight, 500);
    chk("t4_no_count", item_count, 0);
    steps(0, 3);
    chk("t4_still_held", weight, 500);
    step(0);
    chk("t4_removed", weight, 0);
    chk("t4_count", item_count, 1);
    chk("t4_empty", state, 0);

    // Jitter within tolerance, then a window restart.
    step(500); step(502); step(499);
    chk("t3_settling", state, 1);
    step(501);
    chk("t3_jitter_weight", weight, 500);
    steps(0, 4);
    chk("t3_count2", item_count, 2);
    step(500);
    steps(510, 3);
    chk("t3_restart_wait", weight, 0);
    step(510);
    chk("t3_restart_weight", weight, 510);
    steps(0, 4);
    chk("t3_count3", item_count, 3);

    // Aborted settling.
    step(800); step(800); step(2);
    chk("t5_abort_state", state, 0);
    chk("t5_abort_weight", weight, 0);

    // Counter wrap from 0xFFFF.
    force dut.item_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    #1;
    release dut.item_count_q;
    #1;
    chk("t5_preload", item_count, 16'hFFFF);
    steps(900, 4);
    chk("t5_wrap_weight", weight, 900);
    steps(0, 4);
    chk("t5_wrap_count", item_count, 0);

    // Reset mid-item from HOLD(1200), then re-acceptance.
    steps(1200, 4);
    steps(0, 4);
    chk("t6_precount", item_count, 1);
    steps(1200, 4);
    chk("t6_hold", weight, 1200);
    reset = 1'b0;
    #1;
    chk("t6_rst_weight", weight, 0);
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_count", item_count, 0);
    chk("t6_rst_state", state, 0);
    reset = 1'b1;
    steps(1200, 3);
    chk("t6_reaccept_wait", weight, 0);
    step(1200);
    chk("t6_reaccept", weight, 1200);
    steps(0, 4);

    // Randomized item traffic checked by the model every cycle.
    for (int i = 0; i < 200; i++) rand_item();

    steps(0, 2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
